// File: rtl/execute_cc_stage.sv
// Y86-64 execute stage: ALU result, condition codes and branch/cmov condition for one instruction per handshake.
// Latency: 1 cycle from accept to registered outputs. Optional counters under EXEC_PERF_CNT_EN.
// Backpressure: in_ready = !out_valid | out_ready; a stalled result holds every output and the CC register.
module execute_cc_stage #(
    parameter int W  = 64,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    icode,
    input  logic [3:0]    ifun,
    input  logic [W-1:0]  valA,
    input  logic [W-1:0]  valB,
    input  logic [W-1:0]  valC,
    input  logic [RW-1:0] dstE_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  valE,
    output logic          cnd,
    output logic [RW-1:0] dstE_out,
    output logic [3:0]    icode_out,
    output logic [2:0]    cc,
    output logic          op_err
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [31:0]   insn_cnt,
    output logic [31:0]   stall_cnt
`endif
);

    localparam logic [3:0]    I_RRMOV = 4'h2;
    localparam logic [3:0]    I_IRMOV = 4'h3;
    localparam logic [3:0]    I_RMMOV = 4'h4;
    localparam logic [3:0]    I_MRMOV = 4'h5;
    localparam logic [3:0]    I_OPQ   = 4'h6;
    localparam logic [3:0]    I_JXX   = 4'h7;
    localparam logic [3:0]    I_CALL  = 4'h8;
    localparam logic [3:0]    I_RET   = 4'h9;
    localparam logic [3:0]    I_PUSH  = 4'hA;
    localparam logic [3:0]    I_POP   = 4'hB;
    localparam logic [RW-1:0] REG_NONE = {RW{1'b1}};
    localparam logic [W-1:0]  STACK_STEP = W'(8);

    logic          accept;
    logic [W-1:0]  alu_res;
    logic          alu_of;
    logic          alu_ok;
    logic          cond_true;
    logic          cnd_next;
    logic [W-1:0]  vale_next;
    logic [RW-1:0] dst_next;
    logic          op_err_next;
    logic          cc_upd;
    logic          zf;
    logic          sf;
    logic          of;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign zf       = cc[2];
    assign sf       = cc[1];
    assign of       = cc[0];

    // ALU: valB op valA with signed-overflow detection for add/sub
    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        alu_ok  = 1'b1;
        case (ifun)
            4'h0: begin
                alu_res = valB + valA;
                alu_of  = (valA[W-1] == valB[W-1]) && (alu_res[W-1] != valB[W-1]);
            end
            4'h1: begin
                alu_res = valB - valA;
                alu_of  = (valA[W-1] != valB[W-1]) && (alu_res[W-1] != valB[W-1]);
            end
            4'h2:    alu_res = valB & valA;
            4'h3:    alu_res = valB ^ valA;
            default: alu_ok  = 1'b0;
        endcase
    end

    // Condition evaluation against the flags as they stood before this instruction
    always_comb begin
        cond_true = 1'b0;
        case (ifun)
            4'h0:    cond_true = 1'b1;
            4'h1:    cond_true = (sf ^ of) | zf;
            4'h2:    cond_true = sf ^ of;
            4'h3:    cond_true = zf;
            4'h4:    cond_true = !zf;
            4'h5:    cond_true = !(sf ^ of);
            4'h6:    cond_true = !(sf ^ of) && !zf;
            default: cond_true = 1'b0;
        endcase
        cnd_next = ((icode == I_RRMOV) || (icode == I_JXX)) && cond_true;
    end

    // valE selection by instruction class; a not-taken cmov writes no register
    always_comb begin
        vale_next = '0;
        case (icode)
            I_RRMOV:          vale_next = valA;
            I_IRMOV:          vale_next = valC;
            I_RMMOV, I_MRMOV: vale_next = valB + valC;
            I_OPQ:            vale_next = alu_ok ? alu_res : '0;
            I_CALL, I_PUSH:   vale_next = valB - STACK_STEP;
            I_RET, I_POP:     vale_next = valB + STACK_STEP;
            default:          vale_next = '0;
        endcase
        op_err_next = (icode == I_OPQ) && !alu_ok;
        dst_next    = ((icode == I_RRMOV) && !cnd_next) ? REG_NONE : dstE_in;
        cc_upd      = accept && (icode == I_OPQ) && alu_ok && !flush;
    end

    // Output register: load on accept, drop on flush or after consumption
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            valE      <= '0;
            cnd       <= 1'b0;
            dstE_out  <= REG_NONE;
            icode_out <= 4'h0;
            op_err    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            valE      <= vale_next;
            cnd       <= cnd_next;
            dstE_out  <= dst_next;
            icode_out <= icode;
            op_err    <= op_err_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Condition-code register, written only by a legal, unflushed OPq
    always_ff @(posedge clk) begin
        if (rst) begin
            cc <= 3'b100;
        end else if (cc_upd) begin
            cc <= {(alu_res == '0), alu_res[W-1], alu_of};
        end
    end

`ifdef EXEC_PERF_CNT_EN
    // Retired-instruction and output-stall counters, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            insn_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept && !flush) begin
                insn_cnt <= insn_cnt + 32'd1;
            end
            if (out_valid && !out_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
